two_bit_mult_sequencer: RTL
===========================

// Module: two_bit_mult_sequencer
// PURPOSE
// - Multi-cycle 16x16 unsigned multiplier built around the combinational two-bit multiplier stage.
// - Accepts full operands over valid/ready and walks B in N-bit nibbles.
// - Splits each nibble into sub-terms with at most two set bits and drives them into the multiplier.
// - Shifts each returned partial product by its nibble position, accumulates it, and returns the 32-bit product over valid/ready.
// PARAMETERS
// - N    4   nibble width fed to the multiplier's b port; must divide 16
// - NUM  16/N  number of nibbles per operand (localparam, derived)
// PORTS
// - clk             in   1   clock, single domain
// - rst_n           in   1   reset, asynchronous, active-low
// - in_vld          in   1   operand valid
// - in_rdy          out  1   operand ready; high only in IDLE
// - in_a            in   16  multiplicand
// - in_b            in   16  multiplier
// - mul_a           out  16  to multiplier a; registered copy of in_a
// - mul_b           out  N   to multiplier b; sub-term with <=2 set bits
// - mul_vld         out  1   to multiplier vld
// - mul_c           in   32  from multiplier c (same-cycle, combinational)
// - mul_result_vld  in   1   from multiplier result_vld
// - out_vld         out  1   product valid
// - out_rdy         in   1   product ready
// - out_p           out  32  product in_a*in_b
// - busy            out  1   state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, a_q/b_q/acc/idx/rem cleared.
//   - Outputs during and after reset: in_rdy=1, mul_vld=0, mul_b=0, mul_a=0, out_vld=0, out_p=0, busy=0.
//   - A reset mid-operation discards all work; no partial out_vld.
// - FSM states IDLE -> RUN -> DONE -> IDLE.
// - IDLE: in_vld&in_rdy at edge k captures a_q=in_a, b_q=in_b, acc=0, idx=0, rem=b_q[N-1:0]; go RUN.
// - RUN: mul_vld=1 every cycle; mul_a=a_q.
//   - popcount(rem)<=2: mul_b=rem; nibble complete. Next edge: idx++, rem=next nibble.
//   - popcount(rem)>2: mul_b=lowest two set bits of rem. Next edge: rem clears those two bits, idx holds.
//   - Accumulate at each RUN edge when mul_result_vld=1: acc += (mul_c << idx*N), truncated to 32b (no overflow for 16x16).
//   - If mul_result_vld=0, no accumulation occurs and the term is not retired: rem/idx hold and the term is reissued.
//   - Completing the last nibble (idx==NUM-1) -> DONE.
// - DONE: out_vld=1, out_p=acc; both held stable until out_rdy.
//   - out_vld&out_rdy -> IDLE next edge.
//   - in_rdy=0 in RUN/DONE; in_vld is ignored there.
// - Cycle counts:
//   - RUN cycles = sum over nibbles of (1 if popcount<=2, else 2).
//   - out_vld rises the cycle after the last RUN cycle.
//   - Best-case issue-to-issue throughput (out_rdy tied high) = RUN cycles + 2.
// - mul_b outside RUN is 0; idx wraps only via return to IDLE.
// CONFIGURATION
// - ZERO_NIBBLE_SKIP_EN defined:
//   - Zero nibbles are never issued. On entering RUN and after each completed nibble, idx jumps to the next nonzero nibble.
//   - If no nonzero nibble remains, go to DONE; for in_b==0, IDLE -> DONE directly with out_p=0 and no mul_vld pulse.
// - ZERO_NIBBLE_SKIP_EN undefined:
//   - Every nibble takes >=1 RUN cycle; zero nibbles are issued as mul_b=0 with mul_vld=1 and add 0.
// TESTING
// 1. No macro, a=3, b=5 -> 4 RUN cycles, mul_b seq 5,0,0,0; out_p=0x0000000F.
// 2. a=0xFFFF, b=0xFFFF -> 8 RUN cycles, mul_b seq per nibble 3,C; out_p=0xFFFE0001.
// 3. Macro on, a=0x1234, b=0x8421 -> 4 RUN cycles, mul_b 1,2,4,8; out_p=0x096528B4.
// 4. Macro on, b=0 -> no mul_vld pulse, out_vld cycle after accept, out_p=0.
// 5. Macro off, b=0 -> 4 RUN cycles of mul_b=0, out_p=0.
// 6. out_rdy low 5 cycles in DONE -> out_vld/out_p stable, in_rdy=0, in_vld ignored; accepts next op after release.
// 7. rst_n low during 3rd RUN cycle -> immediate out_vld=0, mul_vld=0, in_rdy=1; next op (a=2, b=3) yields out_p=6.

Source files
------------

// File: rtl/two_bit_mult_sequencer_if.sv
// Bundle of the operand, multiplier-stage and product channels of two_bit_mult_sequencer.
// Every channel uses valid/ready: a beat transfers on a clock edge where valid and ready are both high.
// A producer holds its payload stable while valid is high and ready is low.
// mul_c/mul_result_vld answer the same cycle's mul_a/mul_b/mul_vld.
interface two_bit_mult_sequencer_if #(
    parameter int N = 4
);
    logic          in_vld;
    logic          in_rdy;
    logic [15:0]   in_a;
    logic [15:0]   in_b;
    logic [15:0]   mul_a;
    logic [N-1:0]  mul_b;
    logic          mul_vld;
    logic [31:0]   mul_c;
    logic          mul_result_vld;
    logic          out_vld;
    logic          out_rdy;
    logic [31:0]   out_p;

    // Sequencer side.
    modport slave (
        input  in_vld, in_a, in_b, mul_c, mul_result_vld, out_rdy,
        output in_rdy, mul_a, mul_b, mul_vld, out_vld, out_p
    );

    // Environment side: operand source, multiplier stage and product sink.
    modport master (
        output in_vld, in_a, in_b, mul_c, mul_result_vld, out_rdy,
        input  in_rdy, mul_a, mul_b, mul_vld, out_vld, out_p
    );
endinterface

// File: rtl/two_bit_mult_sequencer.sv
// Multi-cycle 16x16 unsigned multiplier that feeds B to a two-bit multiplier stage in sub-terms.
// Optional ZERO_NIBBLE_SKIP_EN: zero nibbles of B are never issued.
module two_bit_mult_sequencer #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    two_bit_mult_sequencer_if.slave   bus,
    output logic                      busy
);
    localparam int NUM   = 16 / N;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d;
    logic [15:0]        b_q, b_d;
    logic [31:0]        acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       rem_q, rem_d;

    logic [N-1:0]       low1, rest, low2, term;
    logic               nib_last;
    logic               have_next;
    logic [IDX_W-1:0]   next_idx;
    logic [31:0]        shifted;
`ifdef ZERO_NIBBLE_SKIP_EN
    logic [IDX_W:0]     nz_run, nz_acc;
`endif

    function automatic logic [N-1:0] nib_of(input logic [15:0] b, input logic [IDX_W-1:0] i);
        logic [15:0] sh;
        sh = b >> (int'(i) * N);
        return sh[N-1:0];
    endfunction

`ifdef ZERO_NIBBLE_SKIP_EN
    // {found, index} of the lowest nonzero nibble at or above start.
    function automatic logic [IDX_W:0] next_nz(input logic [15:0] b, input int start);
        logic [IDX_W:0] r;
        r = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (k >= start && nib_of(b, IDX_W'(k)) != '0) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        rem_d   = rem_q;

        bus.in_rdy  = 1'b0;
        bus.mul_a   = a_q;
        bus.mul_b   = '0;
        bus.mul_vld = 1'b0;
        bus.out_vld = 1'b0;
        bus.out_p   = '0;
        busy        = (state_q != IDLE);

        // A nibble with more than two set bits is split: its lowest two set bits go first.
        low1     = rem_q & (~rem_q + 1'b1);
        rest     = rem_q & ~low1;
        low2     = rest & (~rest + 1'b1);
        nib_last = ($countones(rem_q) <= 2);
        term     = nib_last ? rem_q : (low1 | low2);
        shifted  = bus.mul_c << (int'(idx_q) * N);

`ifdef ZERO_NIBBLE_SKIP_EN
        nz_run    = next_nz(b_q, int'(idx_q) + 1);
        nz_acc    = next_nz(bus.in_b, 0);
        have_next = nz_run[IDX_W];
        next_idx  = nz_run[IDX_W-1:0];
`else
        have_next = (idx_q != IDX_W'(NUM - 1));
        next_idx  = idx_q + 1'b1;
`endif

        case (state_q)
            IDLE: begin
                bus.in_rdy = 1'b1;
                if (bus.in_vld) begin
                    a_d   = bus.in_a;
                    b_d   = bus.in_b;
                    acc_d = '0;
`ifdef ZERO_NIBBLE_SKIP_EN
                    if (nz_acc[IDX_W]) begin
                        idx_d   = nz_acc[IDX_W-1:0];
                        rem_d   = nib_of(bus.in_b, nz_acc[IDX_W-1:0]);
                        state_d = RUN;
                    end else begin
                        idx_d   = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end
`else
                    idx_d   = '0;
                    rem_d   = bus.in_b[N-1:0];
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                bus.mul_vld = 1'b1;
                bus.mul_b   = term;
                // Without a result the term is simply reissued next cycle.
                if (bus.mul_result_vld) begin
                    acc_d = acc_q + shifted;
                    if (nib_last) begin
                        if (have_next) begin
                            idx_d = next_idx;
                            rem_d = nib_of(b_q, next_idx);
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        rem_d = rem_q & ~term;
                    end
                end
            end
            DONE: begin
                bus.out_vld = 1'b1;
                bus.out_p   = acc_q;
                if (bus.out_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
